// File: rtl/uart_baud_tick_gen.sv
// rtl/uart_baud_tick_gen.sv - fractional-N UART baud tick generator
// Emits single-cycle rx/tx enable ticks from a Q(DIV_W.FRAC_W) clk-per-rx-tick divisor.
module uart_baud_tick_gen #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2:0]              baud_sel,
  input  logic [DIV_W+FRAC_W-1:0] custom_div,
  input  logic                    rx_resync,
  output logic                    rx_tick,
  output logic                    rx_sample,
  output logic                    rx_bit_end,
  output logic                    tx_tick,
  output logic                    cfg_err
);

  localparam int Q_W  = DIV_W + FRAC_W;
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  // Rounded divisor in clk cycles per rx tick, scaled by 2^FRAC_W.
  function automatic logic [Q_W-1:0] table_div(input int baud);
    longint num;
    longint den;
    longint d;
    num = longint'(CLK_FREQ) << FRAC_W;
    den = longint'(baud) * OVERSAMPLE;
    d   = (num + den / 2) / den;
    return d[Q_W-1:0];
  endfunction

  localparam logic [Q_W-1:0] DIV_9600   = table_div(9600);
  localparam logic [Q_W-1:0] DIV_19200  = table_div(19200);
  localparam logic [Q_W-1:0] DIV_38400  = table_div(38400);
  localparam logic [Q_W-1:0] DIV_57600  = table_div(57600);
  localparam logic [Q_W-1:0] DIV_115200 = table_div(115200);
  localparam logic [Q_W-1:0] DIV_230400 = table_div(230400);
  localparam logic [Q_W-1:0] DIV_460800 = table_div(460800);

  logic [2:0]        sel_q;
  logic [Q_W-1:0]    custom_q;
  logic [DIV_W-1:0]  div_i;
  logic [FRAC_W-1:0] div_f;
  logic [DIV_W-1:0]  per_cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic              carry_q;
  logic [OS_W-1:0]   rx_os;
  logic [OS_W-1:0]   tx_os;

  logic [Q_W-1:0]    sel_div;
  logic [DIV_W-1:0]  new_i;
  logic [FRAC_W-1:0] new_f;
  logic              new_err;
  logic              cfg_change;
  logic [DIV_W:0]    period_m1;
  logic              tick_cyc;
  logic [FRAC_W:0]   frac_sum;

  always_comb begin
    sel_div = custom_div;
    case (baud_sel)
      3'b000:  sel_div = DIV_9600;
      3'b001:  sel_div = DIV_19200;
      3'b010:  sel_div = DIV_38400;
      3'b011:  sel_div = DIV_57600;
      3'b100:  sel_div = DIV_115200;
      3'b101:  sel_div = DIV_230400;
      3'b110:  sel_div = DIV_460800;
      default: sel_div = custom_div;
    endcase
  end

  // Integer parts below 2 would let ticks run back-to-back; force a 2-cycle period.
  always_comb begin
    new_i   = sel_div[Q_W-1:FRAC_W];
    new_f   = sel_div[FRAC_W-1:0];
    new_err = 1'b0;
    if (sel_div[Q_W-1:FRAC_W] < DIV_W'(2)) begin
      new_i   = DIV_W'(2);
      new_f   = '0;
      new_err = 1'b1;
    end
  end

  assign cfg_change = (baud_sel != sel_q) ||
                      ((baud_sel == 3'b111) && (custom_div != custom_q));

  // Current period length is I plus the carry from the previous fractional step.
  assign period_m1 = {1'b0, div_i} + {{DIV_W{1'b0}}, carry_q} - {{DIV_W{1'b0}}, 1'b1};
  assign tick_cyc  = ({1'b0, per_cnt} == period_m1);
  assign frac_sum  = {1'b0, frac_acc} + {1'b0, div_f};

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q      <= baud_sel;
      custom_q   <= custom_div;
      div_i      <= new_i;
      div_f      <= new_f;
      cfg_err    <= new_err;
      per_cnt    <= '0;
      frac_acc   <= '0;
      carry_q    <= 1'b0;
      rx_os      <= '0;
      tx_os      <= '0;
      rx_tick    <= 1'b0;
      rx_sample  <= 1'b0;
      rx_bit_end <= 1'b0;
      tx_tick    <= 1'b0;
    end else begin
      rx_tick    <= 1'b0;
      rx_sample  <= 1'b0;
      rx_bit_end <= 1'b0;
      tx_tick    <= 1'b0;
      if (cfg_change) begin
        sel_q    <= baud_sel;
        custom_q <= custom_div;
        div_i    <= new_i;
        div_f    <= new_f;
        cfg_err  <= new_err;
        per_cnt  <= '0;
        frac_acc <= '0;
        carry_q  <= 1'b0;
        rx_os    <= '0;
        tx_os    <= '0;
      end else if (!enable) begin
        per_cnt  <= '0;
        frac_acc <= '0;
        carry_q  <= 1'b0;
        rx_os    <= '0;
        tx_os    <= '0;
      end else begin
        if (tick_cyc) begin
          per_cnt  <= '0;
          frac_acc <= frac_sum[FRAC_W-1:0];
          carry_q  <= frac_sum[FRAC_W];
          tx_os    <= tx_os + 1'b1;
          rx_tick  <= 1'b1;
          tx_tick  <= (tx_os == OS_LAST);
        end else begin
          per_cnt <= per_cnt + 1'b1;
        end
        // A resync on a tick cycle keeps the rx_tick but drops that tick's phase markers.
        if (rx_resync) begin
          rx_os <= '0;
        end else if (tick_cyc) begin
          rx_os      <= rx_os + 1'b1;
          rx_sample  <= (rx_os == OS_MID);
          rx_bit_end <= (rx_os == OS_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// tb/tb_uart_baud_tick_gen.sv - self-checking bench for uart_baud_tick_gen
// Closed-form tick-time model compared every cycle, plus directed literal checks.
module tb_uart_baud_tick_gen;

  localparam int CLK_FREQ = 50_000_000;
  localparam int OS       = 16;
  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int BAUDS [7] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  baud_sel = 3'd0;
  logic [19:0] custom_div = 20'h00100;
  logic        rx_resync = 1'b0;
  logic        rx_tick, rx_sample, rx_bit_end, tx_tick, cfg_err;

  uart_baud_tick_gen #(
    .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .baud_sel(baud_sel),
    .custom_div(custom_div), .rx_resync(rx_resync), .rx_tick(rx_tick),
    .rx_sample(rx_sample), .rx_bit_end(rx_bit_end), .tx_tick(tx_tick), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;

  int     m_sel, m_cust, m_i, m_f;
  bit     m_err;
  longint m_seg, m_k;
  int     m_rx;
  bit     e_rxt, e_samp, e_end, e_tx;
  bit     model_ok = 0;

  longint tk_t [4096];
  int     tk_n = 0;
  int     last_samp_tk = 0, last_end_tk = 0;
  longint tx_prev = 0, tx_last = 0;
  int     tx_n = 0;

  task automatic div_of(input int sel, input int cust, output int i, output int f, output bit err);
    int d;
    if (sel == 7) d = cust;
    else d = int'(real'(CLK_FREQ) * (2.0 ** FRAC_W) / (real'(BAUDS[sel]) * OS));
    i = d / (2 ** FRAC_W);
    f = d % (2 ** FRAC_W);
    err = 0;
    if (i < 2) begin i = 2; f = 0; err = 1; end
  endtask

  // Model: k-th tick of a run lands at cycle k*I + floor((k-1)*F/2^FRAC_W) - 1 of that run.
  initial forever begin
    @(posedge clk);
    e_rxt = 0; e_samp = 0; e_end = 0; e_tx = 0;
    if (reset || baud_sel != 3'(m_sel) || (baud_sel == 3'd7 && int'(custom_div) != m_cust)) begin
      m_sel = int'(baud_sel);
      m_cust = int'(custom_div);
      div_of(m_sel, m_cust, m_i, m_f, m_err);
      m_seg = 0; m_k = 0; m_rx = 0;
      if (reset) model_ok = 1;
    end else if (!enable) begin
      m_seg = 0; m_k = 0; m_rx = 0;
    end else begin
      bit tick;
      tick  = (m_seg == (m_k + 1) * m_i + (m_k * m_f) / (2 ** FRAC_W) - 1);
      e_rxt = tick;
      e_tx  = tick && ((m_k + 1) % OS == 0);
      if (rx_resync) m_rx = 0;
      else if (tick) begin
        e_samp = (m_rx % OS == OS / 2 - 1);
        e_end  = (m_rx % OS == OS - 1);
        m_rx++;
      end
      if (tick) m_k++;
      m_seg++;
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (model_ok) begin
      n_checks++;
      if ({rx_tick, rx_sample, rx_bit_end, tx_tick, cfg_err} !== {e_rxt, e_samp, e_end, e_tx, m_err}) begin
        n_fail++;
        $display("FAIL cycle_compare cyc=%0d got=%b exp=%b", cyc,
                 {rx_tick, rx_sample, rx_bit_end, tx_tick, cfg_err}, {e_rxt, e_samp, e_end, e_tx, m_err});
      end
    end
    if (rx_tick === 1'b1) begin
      tk_t[tk_n % 4096] = cyc;
      tk_n++;
    end
    if (rx_sample === 1'b1) last_samp_tk = tk_n;
    if (rx_bit_end === 1'b1) last_end_tk = tk_n;
    if (tx_tick === 1'b1) begin
      tx_prev = tx_last; tx_last = cyc; tx_n++;
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int start = tk_n;
    int c = 0;
    while (tk_n - start < n && c < budget) begin step(); c++; end
    if (tk_n - start < n) chk("timeout_rx_ticks", tk_n - start, n);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int start = tx_n;
    int c = 0;
    while (tx_n - start < n && c < budget) begin step(); c++; end
    if (tx_n - start < n) chk("timeout_tx_ticks", tx_n - start, n);
  endtask

  function automatic longint tdiff(input int a, input int b);
    return tk_t[b % 4096] - tk_t[a % 4096];
  endfunction

  initial begin
    int base;
    longint en_cyc;
    step(); step();
    reset = 0;
    step();
    chk("reset_outputs", {rx_tick, rx_sample, rx_bit_end, tx_tick, cfg_err}, 0);

    enable = 1; en_cyc = cyc; base = tk_n;
    wait_ticks(6, 3000);
    chk("sel0_first_period", tk_t[base % 4096] - en_cyc, 325);
    chk("sel0_period2", tdiff(base, base + 1), 325);
    chk("sel0_period3", tdiff(base + 1, base + 2), 326);
    chk("sel0_period4", tdiff(base + 2, base + 3), 325);
    chk("sel0_period5", tdiff(base + 3, base + 4), 326);
    wait_tx(2, 12000);
    chk("sel0_tx_span", tx_last - tx_prev, 5208);

    baud_sel = 3'd4;
    step();
    chk("change_cycle_zero", {rx_tick, rx_sample, rx_bit_end, tx_tick}, 0);
    base = tk_n;
    wait_ticks(1026, 30000);
    chk("sel4_1024_span", tdiff(base, base + 1024), 27776);
    chk("sel4_sample_phase", (last_samp_tk - base) % 16, 8);
    chk("sel4_bitend_phase", (last_end_tk - base) % 16, 0);

    baud_sel = 3'd7; custom_div = 20'h00018;
    step();
    base = tk_n;
    wait_ticks(3, 100);
    chk("clamp_cfg_err", cfg_err, 1);
    chk("clamp_period", tdiff(base + 1, base + 2), 2);
    custom_div = 20'h00100;
    step();
    base = tk_n;
    wait_ticks(3, 200);
    chk("custom_cfg_err", cfg_err, 0);
    chk("custom_period", tdiff(base + 1, base + 2), 16);

    baud_sel = 3'd4;
    step();
    wait_ticks(5, 400);
    rx_resync = 1; step(); rx_resync = 0;
    base = tk_n;
    wait_ticks(16, 1000);
    chk("resync_sample_after", last_samp_tk - base, 8);
    chk("resync_bitend_after", last_end_tk - base, 16);
    wait_tx(2, 2000);
    chk("resync_tx_span", tx_last - tx_prev, 434);

    baud_sel = 3'd7; custom_div = 20'h00020;
    step();
    wait_ticks(7, 100);
    step();
    rx_resync = 1; step(); rx_resync = 0;
    chk("resync_on_tick_rx_tick", rx_tick, 1);
    chk("resync_on_tick_marks", {rx_sample, rx_bit_end}, 0);
    base = tk_n;
    wait_ticks(10, 100);
    chk("resync_on_tick_next_sample", last_samp_tk - base, 8);

    baud_sel = 3'd4;
    step();
    wait_ticks(20, 1000);
    step(); step(); step();
    baud_sel = 3'd1;
    step();
    chk("sel_change_zero", {rx_tick, rx_sample, rx_bit_end, tx_tick}, 0);
    base = tk_n;
    wait_ticks(6, 2000);
    chk("sel1_period2", tdiff(base, base + 1), 162);
    chk("sel1_period3", tdiff(base + 1, base + 2), 163);
    chk("sel1_period4", tdiff(base + 2, base + 3), 163);
    chk("sel1_period6", tdiff(base + 4, base + 5), 162);
    wait_ticks(7, 2000);
    reset = 1; step(); reset = 0;
    chk("reset_mid_run", {rx_tick, rx_sample, rx_bit_end, tx_tick}, 0);

    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 4);
      if (r == 4) begin
        baud_sel = 3'd7; custom_div = 20'($urandom_range(16, 400));
      end else begin
        baud_sel = 3'(r + 3);
      end
      for (int c = 0; c < int'($urandom_range(50, 400)); c++) begin
        rx_resync = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 99) == 0) enable = ~enable;
        reset = ($urandom_range(0, 499) == 0);
        step();
      end
      rx_resync = 0; reset = 0; enable = 1;
    end
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
